// File: rtl/pc_ctrl_seq.sv
// Purpose : four-phase sequencer owning the PC; decodes ir into registered datapath controls.
// Latency : 4 cycles per instruction (FETCH, DECODE, EXEC, WB); new pc visible the cycle after WB.
// Backpr. : none; free-running until MAX_INSNS retire, then parks in HALT until rst.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ins               fetched instruction for the current pc (combinational from yIF)
//   imm, jTarget      sign-extended immediate and jump field from yID
//   zero              ALU zero flag from yEX, sampled at end of EXEC
//   pc, ir            current PC and latched instruction
//   RegWrite/MemWrite write strobes, high only during WB
//   ALUSrc, MemRead, Mem2Reg, op   datapath selects and ALU operation
//   phase             0 FETCH, 1 DECODE, 2 EXEC, 3 WB (HALT reads 0)
//   insCount, halted  retired count (saturating) and halt flag
module pc_ctrl_seq #(
  parameter logic [31:0] ENTRY     = 32'h28,
  parameter int          MAX_INSNS = 43
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic [31:0] imm,
  input  logic [25:0] jTarget,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        Mem2Reg,
  output logic [2:0]  op,
  output logic [1:0]  phase,
  output logic [15:0] insCount,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_INSNS);

  state_t state;

  // Write intents captured at DECODE; only exposed on the strobes during WB.
  logic wr_reg_q, wr_mem_q;
  logic is_beq_q, is_jal_q, zero_q;

  // Combinational decode of the latched instruction
  logic       dec_regwrite, dec_memwrite, dec_alusrc, dec_memread, dec_mem2reg;
  logic       dec_beq, dec_jal;
  logic [2:0] dec_op;

  always_comb begin
    dec_regwrite = 1'b0;
    dec_memwrite = 1'b0;
    dec_alusrc   = 1'b1;
    dec_op       = 3'b010;
    dec_memread  = 1'b0;
    dec_mem2reg  = 1'b0;
    dec_beq      = 1'b0;
    dec_jal      = 1'b0;
    case (ir[6:0])
      7'h33: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b0;
        if (ir[14:12] == 3'b111)                  dec_op = 3'b000;
        else if (ir[14:12] == 3'b110)             dec_op = 3'b001;
        else if (ir[14:12] == 3'b000 && ir[30])   dec_op = 3'b110;
        else                                      dec_op = 3'b010;
      end
      7'h13: dec_regwrite = 1'b1;
      7'h03: begin
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
        dec_mem2reg  = 1'b1;
      end
      7'h23: dec_memwrite = 1'b1;
      7'h63: begin
        dec_alusrc = 1'b0;
        dec_op     = 3'b110;
        // only funct3 000 redirects; other branch flavours fall through
        dec_beq    = (ir[14:12] == 3'b000);
      end
      7'h6F: dec_jal = 1'b1;
      default: ;
    endcase
  end

  // Next-PC arithmetic; bit 28 is always cleared on the new PC.
  logic [31:0] br_off, j_off, pc_off, pc_sum, pc_next;
  logic [15:0] cnt_inc;

  always_comb begin
    br_off = imm << 1;
    j_off  = {6'b0, jTarget} << 2;
    if (is_beq_q && zero_q) pc_off = br_off;
    else if (is_jal_q)      pc_off = j_off;
    else                    pc_off = 32'd4;
    pc_sum  = pc + pc_off;
    pc_next = {pc_sum[31:29], 1'b0, pc_sum[27:0]};
    cnt_inc = (insCount == 16'hFFFF) ? insCount : insCount + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= ENTRY;
      ir       <= 32'd0;
      phase    <= 2'd0;
      insCount <= 16'd0;
      halted   <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
      ALUSrc   <= 1'b1;
      op       <= 3'b010;
      MemRead  <= 1'b0;
      Mem2Reg  <= 1'b0;
      wr_reg_q <= 1'b0;
      wr_mem_q <= 1'b0;
      is_beq_q <= 1'b0;
      is_jal_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= ins;
          state <= S_DECODE;
          phase <= 2'd1;
        end
        S_DECODE: begin
          ALUSrc   <= dec_alusrc;
          op       <= dec_op;
          MemRead  <= dec_memread;
          Mem2Reg  <= dec_mem2reg;
          wr_reg_q <= dec_regwrite;
          wr_mem_q <= dec_memwrite;
          is_beq_q <= dec_beq;
          is_jal_q <= dec_jal;
          state    <= S_EXEC;
          phase    <= 2'd2;
        end
        S_EXEC: begin
          zero_q   <= zero;
          RegWrite <= wr_reg_q;
          MemWrite <= wr_mem_q;
          state    <= S_WB;
          phase    <= 2'd3;
        end
        S_WB: begin
          RegWrite <= 1'b0;
          MemWrite <= 1'b0;
          MemRead  <= 1'b0;
          pc       <= pc_next;
          insCount <= cnt_inc;
          phase    <= 2'd0;
          if (MAX_INSNS != 0 && cnt_inc == MAX_CNT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state  <= S_FETCH;
          end
        end
        S_HALT: begin
          // terminal: everything frozen, strobes already cleared on WB exit
          phase    <= 2'd0;
          RegWrite <= 1'b0;
          MemWrite <= 1'b0;
          MemRead  <= 1'b0;
        end
        default: begin
          state <= S_FETCH;
          phase <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_ctrl_seq.md
# pc_ctrl_seq

Multi-cycle sequencer that drives the single-cycle datapath (yIF, yID, yEX, yDM, yWB) in place of bench-side control. Owns the program counter and decodes the fetched instruction into datapath control signals. Computes the next PC: PC+4, taken beq, or jal. Paces each instruction through a fixed four-phase FSM and halts after a programmable instruction count.

## Interface
- ENTRY, 32'h28, PC value loaded on reset.
- MAX_INSNS, 43, instructions to retire before halting; 0 = run forever.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ins  in  32  instruction from yIF for the current pc (combinational fetch).
- imm  in  32  sign-extended immediate from yID.
- jTarget  in  26  jump field from yID.
- zero  in  1  ALU zero flag from yEX.
- pc  out  32  current PC, drives yIF PCin.
- ir  out  32  latched instruction.
- RegWrite, MemWrite  out  1 each  write strobes.
- ALUSrc, MemRead, Mem2Reg  out  1 each  datapath selects.
- op  out  3  ALU operation.
- phase  out  2  FSM state: 0 FETCH, 1 DECODE, 2 EXEC, 3 WB.
- insCount  out  16  retired-instruction count.
- halted  out  1  high once MAX_INSNS have retired.

## Operation
- FSM: FETCH -> DECODE -> EXEC -> WB -> FETCH. Each step takes 1 cycle; HALT is a terminal state.
- FETCH: pc stable. ins sampled into ir at the end of FETCH.
- DECODE: controls are decoded from ir and registered. They are valid from the start of EXEC through the end of WB.
- Decode of ir[6:0]; fields not listed keep their defaults. Defaults: RegWrite 0, ALUSrc 1, op 010, MemRead 0, MemWrite 0, Mem2Reg 0.
  - 0x33 R-type: RegWrite, ALUSrc=0. op is chosen from funct3 ir[14:12] and ir[30]:
    - funct3 111: op=000.
    - funct3 110: op=001.
    - funct3 000 with ir[30]=1: op=110.
    - otherwise: op=010.
  - 0x13 addi: RegWrite, ALUSrc=1.
  - 0x03 lw: RegWrite, MemRead, Mem2Reg.
  - 0x23 sw: MemWrite.
  - 0x63 beq: ALUSrc=0, op=110.
  - 0x6F jal: no writes.
  - Unknown opcode: defaults, so it executes as a no-op and PC+4.
- Strobe gating: RegWrite and MemWrite are driven high only during WB, for exactly 1 cycle per instruction. MemRead is held through EXEC and WB.
- zero is sampled at the end of EXEC.
- Next PC is computed at the end of WB, mod 2^32, then bit 28 is forced to 0:
  - beq (opcode 0x63, funct3 000) with sampled zero=1: pc + (imm<<1).
  - jal (0x6F): pc + ({6'b0,jTarget}<<2).
  - otherwise: pc + 4.
  - Branches with funct3 != 000 fall through.
- insCount increments at the end of WB and saturates at 16'hFFFF.
- Halt: if MAX_INSNS != 0 and the incremented count equals MAX_INSNS, the FSM enters HALT instead of FETCH.
- HALT behaviour:
  - phase reads 0.
  - halted=1; all strobes and MemRead are 0.
  - pc and insCount are frozen.
  - Exit only via rst.

## Timing
- Reset values (first cycle after rst sampled high):
  - pc=ENTRY, ir=0, phase=0, insCount=0, halted=0.
  - Controls at defaults.
- Latency: 4 cycles per instruction. The register-file and memory write lands on the rising edge ending WB. The new pc is visible in the cycle after WB.
- rst wins over every other event in the same cycle. Reset mid-instruction, including during WB:
  - No PC update and no count increment.
  - Strobes are 0 from the next cycle.
- Control outputs change only on phase transitions and are glitch-free (registered). Strobes are never high outside WB.
- Boundary cases:
  - pc 0x0FFFFFFC + 4 = 0x10000000, which becomes 0x00000000 after the bit-28 clear.
  - Negative imm yields a backward branch.
  - MAX_INSNS=1 halts after the first WB.

## Test plan
- Reset: assert rst for 2 cycles -> pc=0x28, phase=0, insCount=0, halted=0, RegWrite=MemWrite=0.
- addi at 0x28: run 4 cycles -> RegWrite high only in WB cycle, ALUSrc=1, op=010; pc=0x2C in the next FETCH; insCount=1.
- beq with imm=8:
  - zero=1 at end of EXEC -> pc goes 0x28 -> 0x38.
  - Repeat with zero=0 -> pc=0x2C.
  - beq with imm=-4 and zero=1 -> pc goes 0x28 -> 0x20.
- jal with jTarget=3 at 0x30 -> pc=0x3C, no strobes. Separately, lw -> MemRead and Mem2Reg held in EXEC and WB; sw -> MemWrite pulses once in WB.
- Halt with MAX_INSNS=3:
  - Three addi -> halted=1 after the third WB; pc=0x34 frozen.
  - 10 further cycles -> no strobes, insCount=3.
- Reset during WB of sw -> MemWrite=0 from the next cycle, pc=0x28, insCount unchanged from 0. Wrap: ENTRY=0x0FFFFFFC with addi -> next pc=0x00000000.
